// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter that shares one downstream line port between the L1 I-cache and D-cache.
// The grant starts 1 cycle after the request, the response passes through in the same cycle, and one RELEASE cycle follows; the losing requester simply waits.
module l1_mem_arbiter (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_mem_read,
  input  logic [15:0]  i_mem_address,
  output logic [127:0] i_mem_rdata,
  output logic         i_mem_resp,
  input  logic         d_mem_read,
  input  logic         d_mem_write,
  input  logic         d_eviction,
  input  logic [15:0]  d_mem_address,
  input  logic [127:0] d_mem_wdata,
  output logic [127:0] d_mem_rdata,
  output logic         d_mem_resp,
  output logic         l_mem_read,
  output logic         l_mem_write,
  output logic         l_eviction,
  output logic [15:0]  l_mem_address,
  output logic [127:0] l_mem_wdata,
  input  logic [127:0] l_mem_rdata,
  input  logic         l_mem_resp
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

  state_t       r_state;
  state_t       w_next;
  logic         r_last_d;
  logic         r_read;
  logic         r_write;
  logic         r_evict;
  logic [15:0]  r_addr;
  logic [127:0] r_wdata;
  logic         w_req_i;
  logic         w_req_d;
  logic         w_pick_i;
  logic         w_pick_d;

  assign w_req_i  = i_mem_read;
  assign w_req_d  = d_mem_read | d_mem_write;
  // D takes the port unless I is also asking and D was the last one served
  assign w_pick_d = w_req_d & ~(w_req_i & r_last_d);
  assign w_pick_i = w_req_i & ~w_pick_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_d <= 1'b0;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_evict  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (r_state == IDLE) begin
      if (w_pick_d) begin
        r_last_d <= 1'b1;
        r_write  <= d_mem_write;
        r_read   <= d_mem_read & ~d_mem_write;
        r_evict  <= d_eviction & d_mem_write;
        r_addr   <= d_mem_address;
        r_wdata  <= d_mem_wdata;
      end else if (w_pick_i) begin
        r_last_d <= 1'b0;
        r_read   <= 1'b1;
        r_write  <= 1'b0;
        r_evict  <= 1'b0;
        r_addr   <= i_mem_address;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    l_mem_read  = 1'b0;
    l_mem_write = 1'b0;
    l_eviction  = 1'b0;
    i_mem_resp  = 1'b0;
    d_mem_resp  = 1'b0;
    i_mem_rdata = '0;
    d_mem_rdata = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_d) begin
          w_next = GRANT_D;
        end else if (w_pick_i) begin
          w_next = GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        l_mem_read  = r_read;
        l_mem_write = r_write;
        l_eviction  = r_evict;
        if (l_mem_resp) begin
          w_next = RELEASE;
        end
      end
      RELEASE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (r_state == GRANT_I) begin
      i_mem_resp  = l_mem_resp;
      i_mem_rdata = l_mem_rdata;
    end
    if (r_state == GRANT_D) begin
      d_mem_resp  = l_mem_resp;
      d_mem_rdata = l_mem_rdata;
    end
  end

  assign l_mem_address = r_addr;
  assign l_mem_wdata   = r_wdata;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Randomised scoreboard bench for l1_mem_arbiter with a round-robin reference model.
module tb_l1_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_mem_read = 1'b0;
  logic [15:0]  i_mem_address = '0;
  logic [127:0] i_mem_rdata;
  logic         i_mem_resp;
  logic         d_mem_read = 1'b0;
  logic         d_mem_write = 1'b0;
  logic         d_eviction = 1'b0;
  logic [15:0]  d_mem_address = '0;
  logic [127:0] d_mem_wdata = '0;
  logic [127:0] d_mem_rdata;
  logic         d_mem_resp;
  logic         l_mem_read;
  logic         l_mem_write;
  logic         l_eviction;
  logic [15:0]  l_mem_address;
  logic [127:0] l_mem_wdata;
  logic [127:0] l_mem_rdata;
  logic         l_mem_resp;

  l1_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
    .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_eviction(d_eviction),
    .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
    .l_mem_read(l_mem_read), .l_mem_write(l_mem_write), .l_eviction(l_eviction),
    .l_mem_address(l_mem_address), .l_mem_wdata(l_mem_wdata),
    .l_mem_rdata(l_mem_rdata), .l_mem_resp(l_mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         rd;
    logic         wr;
    logic         ev;
    logic [15:0]  a;
    logic [127:0] wd;
  } req_t;

  int           pass_cnt = 0;
  int           total_cnt = 0;
  int           cyc = 0;
  req_t         iq[$];
  req_t         dq[$];
  logic [127:0] rsp_q[$];
  int           grant_log[$];
  int           start_log[$];
  int           resp_log[$];
  int           last_len = 0;
  int           ds_delay = 0;
  bit           spur_en = 1'b0;
  bit           ds_fix = 1'b0;
  logic [127:0] ds_fix_data = '0;
  bit           d_granted = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic i_req(input logic [15:0] a, output logic [127:0] rd);
    req_t r;
    bit   got;
    @(posedge clk); #1;
    i_mem_read    = 1'b1;
    i_mem_address = a;
    r = '{rd: 1'b1, wr: 1'b0, ev: 1'b0, a: a, wd: '0};
    iq.push_back(r);
    got = 1'b0;
    rd  = '0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (i_mem_resp) begin
        got = 1'b1;
        rd  = i_mem_rdata;
      end
    end
    if (!got) chk("i_resp_timeout", 1'b0, 0, 1);
    @(posedge clk); #1;
    i_mem_read = 1'b0;
  endtask

  task automatic d_req(input logic rd_i, input logic wr_i, input logic ev_i, input logic [15:0] a,
                       input logic [127:0] wd, input bit scr, input logic [15:0] alt,
                       output logic [127:0] rd);
    req_t r;
    bit   got;
    bit   moved;
    @(posedge clk); #1;
    d_mem_read    = rd_i;
    d_mem_write   = wr_i;
    d_eviction    = ev_i;
    d_mem_address = a;
    d_mem_wdata   = wd;
    r = '{rd: rd_i & ~wr_i, wr: wr_i, ev: ev_i & wr_i, a: a, wd: wd};
    dq.push_back(r);
    got   = 1'b0;
    moved = 1'b0;
    rd    = '0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (d_mem_resp) begin
        got = 1'b1;
        rd  = d_mem_rdata;
      end else if (scr && d_granted && !moved) begin
        // disturb the inputs while the grant is in flight; the latched copy must win
        @(posedge clk); #1;
        d_mem_address = alt;
        d_mem_wdata   = ~wd;
        d_eviction    = ~ev_i;
        moved         = 1'b1;
      end
    end
    if (!got) chk("d_resp_timeout", 1'b0, 0, 1);
    @(posedge clk); #1;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
  endtask

  // downstream memory: answers after ds_delay cycles (random if negative), drives junk otherwise
  initial begin : ds_agent
    bit act;
    int w;
    act = 1'b0;
    w   = 0;
    l_mem_resp  = 1'b0;
    l_mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      l_mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      l_mem_resp  = 1'b0;
      if (l_mem_read | l_mem_write) begin
        if (!act) begin
          act = 1'b1;
          w   = (ds_delay < 0) ? $urandom_range(0, 3) : ds_delay;
        end
        if (w == 0) begin
          if (ds_fix) l_mem_rdata = ds_fix_data;
          l_mem_resp = 1'b1;
          rsp_q.push_back(l_mem_rdata);
          act = 1'b0;
        end else begin
          w--;
        end
      end else begin
        act = 1'b0;
        l_mem_resp = spur_en && ($urandom_range(0, 7) == 0);
      end
    end
  end

  // monitor: reference arbitration model plus per-cycle output checks
  initial begin : monitor
    bit           act;
    int           who;
    req_t         ex;
    int           len;
    int           last_resp;
    bit           exp_start;
    bit           pi;
    bit           pd;
    bit           model_last_d;
    bit           strobe;
    logic         w_resp;
    logic         o_resp;
    logic [127:0] w_dat;
    logic [127:0] o_dat;
    logic [127:0] er;
    act = 0; who = 0; ex = '0; len = 0; last_resp = -10;
    exp_start = 0; pi = 0; pd = 0; model_last_d = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        act = 0; last_resp = -10; exp_start = 0; pi = 0; pd = 0; model_last_d = 0;
        d_granted = 1'b0;
        iq.delete(); dq.delete(); rsp_q.delete();
        continue;
      end
      strobe = l_mem_read | l_mem_write;
      if (!act) begin
        chk("strobe_timing", strobe == exp_start, strobe, exp_start);
        if (strobe) begin
          if (pi && pd) who = model_last_d ? 0 : 1;
          else          who = pd ? 1 : 0;
          model_last_d = (who == 1);
          start_log.push_back(cyc);
          len = 0;
          act = 1;
          if (who == 1 && dq.size() > 0)      ex = dq.pop_front();
          else if (who == 0 && iq.size() > 0) ex = iq.pop_front();
          else begin
            chk("grant_without_request", 1'b0, who, 0);
            act = 0;
          end
        end
      end
      d_granted = act && (who == 1);
      if (act) begin
        len++;
        if (who == 1) begin
          w_resp = d_mem_resp; w_dat = d_mem_rdata; o_resp = i_mem_resp; o_dat = i_mem_rdata;
        end else begin
          w_resp = i_mem_resp; w_dat = i_mem_rdata; o_resp = d_mem_resp; o_dat = d_mem_rdata;
        end
        chk("strobes_addr",
            {l_mem_read, l_mem_write, l_eviction, l_mem_address} == {ex.rd, ex.wr, ex.ev, ex.a},
            {l_mem_read, l_mem_write, l_eviction, l_mem_address}, {ex.rd, ex.wr, ex.ev, ex.a});
        if (ex.wr) chk("wdata", l_mem_wdata == ex.wd, l_mem_wdata, ex.wd);
        chk("other_quiet", !o_resp && o_dat == '0, {o_resp, o_dat}, 0);
        if (l_mem_resp) begin
          er = (rsp_q.size() > 0) ? rsp_q.pop_front() : ~w_dat;
          chk("resp_pulse", w_resp == 1'b1, w_resp, 1);
          chk("resp_data", w_dat == er, w_dat, er);
          grant_log.push_back(d_mem_resp ? 1 : (i_mem_resp ? 0 : -1));
          resp_log.push_back(cyc);
          last_len  = len;
          last_resp = cyc;
          act = 0;
        end else begin
          chk("no_early_resp", w_resp == 1'b0, w_resp, 0);
        end
      end else begin
        chk("idle_quiet", !i_mem_resp && !d_mem_resp && i_mem_rdata == '0 && d_mem_rdata == '0,
            {i_mem_resp, d_mem_resp, i_mem_rdata ^ d_mem_rdata}, 0);
      end
      pi = i_mem_read;
      pd = d_mem_read | d_mem_write;
      exp_start = !strobe && (cyc >= last_resp + 2) && (pi || pd);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    logic [127:0] rdi;
    logic [127:0] rdd;
    logic [127:0] beef;
    int           n0;
    int           s0;
    int           r0;
    bit           seen;
    beef = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;

    repeat (3) @(posedge clk); #1;
    chk("rst_strobes", {l_mem_read, l_mem_write, l_eviction} == 3'b000, {l_mem_read, l_mem_write, l_eviction}, 0);
    chk("rst_addr", l_mem_address == '0, l_mem_address, 0);
    chk("rst_wdata", l_mem_wdata == '0, l_mem_wdata, 0);
    chk("rst_resp", {i_mem_resp, d_mem_resp} == 2'b00, {i_mem_resp, d_mem_resp}, 0);
    chk("rst_rdata", i_mem_rdata == '0 && d_mem_rdata == '0, i_mem_rdata | d_mem_rdata, 0);
    reset_n = 1'b1;

    // tie straight out of reset: D first, I restarts 3 cycles after the first response
    ds_delay = 0;
    n0 = grant_log.size(); s0 = start_log.size(); r0 = resp_log.size();
    fork
      i_req(16'h0100, rdi);
      d_req(1'b1, 1'b0, 1'b0, 16'h0200, '0, 1'b0, '0, rdd);
    join
    chk("tie_first_D", at(grant_log, n0) == 1, at(grant_log, n0), 1);
    chk("tie_second_I", at(grant_log, n0 + 1) == 0, at(grant_log, n0 + 1), 0);
    chk("restart_gap", at(start_log, s0 + 1) - at(resp_log, r0) == 3,
        at(start_log, s0 + 1) - at(resp_log, r0), 3);

    // lone I read answered after 2 wait cycles
    ds_delay = 2; ds_fix = 1'b1; ds_fix_data = beef;
    i_req(16'h1230, rdi);
    ds_fix = 1'b0;
    chk("iread_len", last_len == 3, last_len, 3);
    chk("iread_data", rdi == beef, rdi, beef);

    // D victim eviction
    ds_delay = 1;
    n0 = grant_log.size();
    d_req(1'b0, 1'b1, 1'b1, 16'h4440, {16{8'hA5}}, 1'b0, '0, rdd);
    chk("evict_granted_D", at(grant_log, n0) == 1, at(grant_log, n0), 1);

    // address change mid-grant must not reach the port
    ds_delay = 3;
    d_req(1'b1, 1'b0, 1'b0, 16'h1000, {4{$urandom}}, 1'b1, 16'h2000, rdd);
    chk("isolation_len", last_len == 4, last_len, 4);

    // served I last, so continuous contention must alternate starting with D
    ds_delay = 0;
    i_req(16'h0300, rdi);
    n0 = grant_log.size();
    fork
      begin
        for (int n = 0; n < 3; n++) i_req(16'($urandom), rdi);
      end
      begin
        for (int n = 0; n < 3; n++)
          d_req(1'($urandom), 1'b1, 1'($urandom), 16'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0, rdd);
      end
    join
    for (int k = 0; k < 6; k++)
      chk("rr_order", at(grant_log, n0 + k) == ((k % 2 == 0) ? 1 : 0), at(grant_log, n0 + k), (k % 2 == 0) ? 1 : 0);

    // random traffic with spurious downstream responses while idle
    spur_en = 1'b1; ds_delay = -1;
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          i_req(16'($urandom), rdi);
        end
      end
      begin
        for (int n = 0; n < 30; n++) begin
          int sel;
          sel = $urandom_range(0, 9);
          repeat ($urandom_range(0, 3)) @(posedge clk);
          d_req((sel < 5) || (sel == 9), sel >= 5, 1'($urandom), 16'($urandom),
                {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 16'($urandom), rdd);
        end
      end
    join
    spur_en = 1'b0;

    // asynchronous reset in the middle of an I grant
    ds_delay = 20;
    @(posedge clk); #1;
    i_mem_read = 1'b1; i_mem_address = 16'h5550;
    iq.push_back('{rd: 1'b1, wr: 1'b0, ev: 1'b0, a: 16'h5550, wd: '0});
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (l_mem_read) seen = 1'b1;
    end
    chk("arst_grant_seen", seen, seen, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_strobes", {l_mem_read, l_mem_write, l_eviction} == 3'b000, {l_mem_read, l_mem_write, l_eviction}, 0);
    chk("arst_latches", l_mem_address == '0 && l_mem_wdata == '0, {l_mem_address, l_mem_wdata[15:0]}, 0);
    chk("arst_resp", {i_mem_resp, d_mem_resp} == 2'b00 && i_mem_rdata == '0, {i_mem_resp, d_mem_resp, i_mem_rdata}, 0);
    i_mem_read = 1'b0;
    repeat (2) @(posedge clk); #1;
    reset_n  = 1'b1;
    ds_delay = 0;
    n0 = grant_log.size();
    fork
      i_req(16'h0600, rdi);
      d_req(1'b1, 1'b0, 1'b0, 16'h0700, '0, 1'b0, '0, rdd);
    join
    chk("post_rst_first_D", at(grant_log, n0) == 1, at(grant_log, n0), 1);
    chk("post_rst_second_I", at(grant_log, n0 + 1) == 0, at(grant_log, n0 + 1), 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
